uart_rx: RTL and testbench

- UART serial receiver, 8N1 framing. Counterpart to the team's UART transmitter.
- Synchronises the asynchronous Rx line and detects the start-bit falling edge.
- Samples each bit at mid-bit using a baud counter and assembles the byte LSB-first.
- Holds the received byte behind a ready/ack handshake to the consumer and flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync.sv | 26 ++
 rtl/uart_rx.sv | 137 +++++++++++++
 tb/tb_uart_rx.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing constants,
// common to the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a selectable reset value.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, LSB-first assembly, and a ready/ack handshake
// with sticky framing-error and overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 byte_ready_o,
    input  logic                 byte_ack_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    rx_state_t              state_q;
    logic [CNT_W-1:0]       baud_q;
    logic [BIT_W-1:0]       bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   ready_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   armed_q;
    logic                   rx_s;
    logic                   ack_taken;

    uart_sync #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (rx_i),
        .q_o    (rx_s)
    );

    assign ack_taken = byte_ack_i && ready_q;

    // A completing frame overrides a same-cycle ack, since its assignments come last.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            if (ack_taken) begin
                ready_q     <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    // After a frame the line must be seen high again, so a break cannot retrigger.
                    if (rx_s) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q <= START;
                    end
                end

                START: begin
                    if (baud_q == BAUD_HALF) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s ? IDLE : DATA;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q         <= '0;
                        shift_q[bit_q] <= rx_s;
                        if (bit_q == BIT_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q  <= '0;
                        data_q  <= shift_q;
                        ready_q <= 1'b1;
                        armed_q <= 1'b0;
                        state_q <= IDLE;
                        if (ack_taken) begin
                            frame_err_q <= ~rx_s;
                            overrun_q   <= 1'b0;
                        end else begin
                            frame_err_q <= frame_err_q | ~rx_s;
                            overrun_q   <= overrun_q | ready_q;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_o       = data_q;
    assign byte_ready_o = ready_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit: normal frames, glitch rejection,
// framing error, overrun, ack/completion collision, break and mid-frame reset.
module tb_uart_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       resetIn;
    logic       rxLine;
    logic       byteAck;
    logic [7:0] dataOut;
    logic       readyOut;
    logic       frameErrOut;
    logic       overrunOut;
    logic       busyOut;

    int checkCount = 0;
    int errorCount = 0;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk_i       (clk),
        .reset_i     (resetIn),
        .rx_i        (rxLine),
        .data_o      (dataOut),
        .byte_ready_o(readyOut),
        .byte_ack_i  (byteAck),
        .frame_err_o (frameErrOut),
        .overrun_o   (overrunOut),
        .busy_o      (busyOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one frame from a negedge, one line value per negedge. The start bit is
    // driven at step 0, so the stop-bit sample lands on the posedge after step 78.
    task automatic applyStimulus(input logic [7:0] value, input logic stopBit,
                                 input int ackAt, input int abortAt);
        logic [9:0] frameBits;
        frameBits = {stopBit, value, 1'b0};
        for (int n = 0; n < 10 * CPB; n++) begin
            if (n == abortAt) begin
                checkOutput("busy_before_abort", 32'(busyOut), 32'd1);
                resetIn = 1'b1;
                rxLine  = 1'b1;
                byteAck = 1'b0;
                @(negedge clk);
                resetIn = 1'b0;
                return;
            end
            rxLine  = frameBits[n / CPB];
            byteAck = (n == ackAt);
            @(negedge clk);
        end
        rxLine  = 1'b1;
        byteAck = 1'b0;
    endtask

    task automatic pulseAck();
        byteAck = 1'b1;
        @(negedge clk);
        byteAck = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        rxLine = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        resetIn = 1'b1;
        rxLine  = 1'b1;
        byteAck = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_data", 32'(dataOut), 32'h00);
        checkOutput("reset_ready", 32'(readyOut), 32'd0);
        checkOutput("reset_ferr", 32'(frameErrOut), 32'd0);
        checkOutput("reset_ovr", 32'(overrunOut), 32'd0);
        checkOutput("reset_busy", 32'(busyOut), 32'd0);
        resetIn = 1'b0;
        idleCycles(4);

        // Clean frame, then ack clears ready on the next edge.
        applyStimulus(8'hA5, 1'b1, -1, -1);
        checkOutput("a5_data", 32'(dataOut), 32'hA5);
        checkOutput("a5_ready", 32'(readyOut), 32'd1);
        checkOutput("a5_ferr", 32'(frameErrOut), 32'd0);
        checkOutput("a5_busy", 32'(busyOut), 32'd0);
        pulseAck();
        checkOutput("a5_ack_ready", 32'(readyOut), 32'd0);
        idleCycles(4);

        // Short low glitch is rejected at the mid-start check.
        rxLine = 1'b0;
        repeat (3) @(negedge clk);
        rxLine = 1'b1;
        @(negedge clk);
        checkOutput("glitch_busy_mid", 32'(busyOut), 32'd1);
        idleCycles(10);
        checkOutput("glitch_busy_end", 32'(busyOut), 32'd0);
        checkOutput("glitch_ready", 32'(readyOut), 32'd0);
        checkOutput("glitch_ferr", 32'(frameErrOut), 32'd0);

        // Framing error still delivers the byte.
        applyStimulus(8'h3C, 1'b0, -1, -1);
        checkOutput("3c_data", 32'(dataOut), 32'h3C);
        checkOutput("3c_ready", 32'(readyOut), 32'd1);
        checkOutput("3c_ferr", 32'(frameErrOut), 32'd1);
        idleCycles(4);
        pulseAck();
        checkOutput("3c_ack_ferr", 32'(frameErrOut), 32'd0);
        checkOutput("3c_ack_ready", 32'(readyOut), 32'd0);
        idleCycles(4);

        // Overrun keeps the newest byte.
        applyStimulus(8'h11, 1'b1, -1, -1);
        idleCycles(4);
        applyStimulus(8'h22, 1'b1, -1, -1);
        checkOutput("ovr_data", 32'(dataOut), 32'h22);
        checkOutput("ovr_flag", 32'(overrunOut), 32'd1);
        checkOutput("ovr_ready", 32'(readyOut), 32'd1);
        pulseAck();
        checkOutput("ovr_ack_flag", 32'(overrunOut), 32'd0);
        checkOutput("ovr_ack_ready", 32'(readyOut), 32'd0);
        idleCycles(4);

        // Pending errored byte acked exactly as 0x55 completes: completion wins.
        applyStimulus(8'h33, 1'b0, -1, -1);
        idleCycles(4);
        applyStimulus(8'h55, 1'b1, 78, -1);
        checkOutput("coll_ready", 32'(readyOut), 32'd1);
        checkOutput("coll_data", 32'(dataOut), 32'h55);
        checkOutput("coll_ovr", 32'(overrunOut), 32'd0);
        checkOutput("coll_ferr", 32'(frameErrOut), 32'd0);
        pulseAck();
        idleCycles(4);

        // Break: line held low well past the stop bit must not restart reception.
        rxLine = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("break_data", 32'(dataOut), 32'h00);
        checkOutput("break_ferr", 32'(frameErrOut), 32'd1);
        checkOutput("break_ready", 32'(readyOut), 32'd1);
        checkOutput("break_busy", 32'(busyOut), 32'd0);
        idleCycles(4);
        pulseAck();
        checkOutput("break_ack_ferr", 32'(frameErrOut), 32'd0);
        idleCycles(4);

        // Reset in the middle of data bit 4 discards the partial byte.
        applyStimulus(8'h0F, 1'b1, -1, 42);
        checkOutput("abort_busy", 32'(busyOut), 32'd0);
        checkOutput("abort_ready", 32'(readyOut), 32'd0);
        checkOutput("abort_data", 32'(dataOut), 32'h00);
        idleCycles(4);
        applyStimulus(8'h80, 1'b1, -1, -1);
        checkOutput("after_abort_data", 32'(dataOut), 32'h80);
        checkOutput("after_abort_ready", 32'(readyOut), 32'd1);
        checkOutput("after_abort_ferr", 32'(frameErrOut), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
